// File: rtl/vote_pkg.sv
// Shared types and default sizing for the voting-session block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vote_pkg;

   // Session phases; the controller stores these in a 2-bit register
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      TALLY   = 2'd2,
      RESULT  = 2'd3
   } vote_state_e;

   localparam int N_VOTERS_DEF = 4;

   // Width needed to hold a count of 0..n
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   localparam int CNT_W_DEF = cnt_w(N_VOTERS_DEF);

endpackage

// File: rtl/vote_session_ctrl_if.sv
// Voter-side inputs and result-side outputs of one voting session.
// Latency: n/a (wiring only).
// Backpressure: none; every field is sampled or driven each cycle.
interface vote_session_ctrl_if
   import vote_pkg::*;
#(
   parameter int N_VOTERS = N_VOTERS_DEF,
   parameter int CNT_W    = CNT_W_DEF
);
   logic                start;
   logic                close;
   logic [N_VOTERS-1:0] ballot_valid;
   logic [N_VOTERS-1:0] ballot_yes;
   logic [N_VOTERS-1:0] voted;
   logic [CNT_W-1:0]    yes_cnt;
   logic                pass;
   logic                tie;
   logic                busy;
   logic                done;

   // Voter/display side: drives requests and ballots, observes results
   modport master (
      output start, close, ballot_valid, ballot_yes,
      input  voted, yes_cnt, pass, tie, busy, done
   );

   // Session controller side
   modport slave (
      input  start, close, ballot_valid, ballot_yes,
      output voted, yes_cnt, pass, tie, busy, done
   );
endinterface

// File: rtl/vote_popcount.sv
// Counts the set bits of the yes-ballot mask (tally datapath).
// Latency: combinational, 0 cycles.
// Backpressure: none.
module vote_popcount #(
   parameter int N     = 4,
   parameter int CNT_W = 3
) (
   input  logic [N-1:0]     vec,
   output logic [CNT_W-1:0] cnt
);

   // Ripple sum of individual bits; N is small so a tree buys nothing
   always_comb begin
      cnt = '0;
      for (int i = 0; i < N; i++) begin
         cnt = cnt + CNT_W'(vec[i]);
      end
   end

endmodule

// File: rtl/vote_session_ctrl.sv
// Runs one ballot window: collect first ballot per voter, close, tally, hold result.
// Latency: last ballot/close in cycle k -> TALLY at k+1 -> done at k+2.
// Backpressure: none; inputs outside their honoured state are simply dropped.
module vote_session_ctrl
   import vote_pkg::*;
#(
   parameter int N_VOTERS    = N_VOTERS_DEF,
   parameter int TIMEOUT_CYC = 16,
   parameter int CNT_W       = cnt_w(N_VOTERS)
) (
   input logic                clk,
   input logic                rst,
   vote_session_ctrl_if.slave bus
);

   localparam logic [1:0] ST_IDLE    = IDLE;
   localparam logic [1:0] ST_COLLECT = COLLECT;
   localparam logic [1:0] ST_TALLY   = TALLY;
   localparam logic [1:0] ST_RESULT  = RESULT;

   localparam int               TMR_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W:0]   NV_EXT   = (CNT_W + 1)'(N_VOTERS);

   logic [1:0]          state_q,    state_d;
   logic [N_VOTERS-1:0] voted_q,    voted_d;
   logic [N_VOTERS-1:0] yes_mask_q, yes_mask_d;
   logic [TMR_W-1:0]    timer_q,    timer_d;
   logic [CNT_W-1:0]    yes_cnt_q,  yes_cnt_d;
   logic                pass_q,     pass_d;
   logic                tie_q,      tie_d;
   logic                busy_q,     busy_d;
   logic                done_q,     done_d;

   logic [N_VOTERS-1:0] new_ballot;
   logic [CNT_W-1:0]    pop;
   logic [CNT_W:0]      pop_x2;

   vote_popcount #(
      .N     (N_VOTERS),
      .CNT_W (CNT_W)
   ) u_popcount (
      .vec (yes_mask_q),
      .cnt (pop)
   );

   // Doubling at one extra bit lets majority/tie compare against N without overflow
   assign pop_x2     = {pop, 1'b0};
   assign new_ballot = bus.ballot_valid & ~voted_q;

   // Next-state logic: FSM, ballot latch, timer and result registers
   always_comb begin
      state_d    = state_q;
      voted_d    = voted_q;
      yes_mask_d = yes_mask_q;
      timer_d    = timer_q;
      yes_cnt_d  = yes_cnt_q;
      pass_d     = pass_q;
      tie_d      = tie_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d    = ST_COLLECT;
               voted_d    = '0;
               yes_mask_d = '0;
               timer_d    = '0;
            end
         end
         ST_COLLECT: begin
            // Only voters without a recorded ballot can write; first ballot wins
            voted_d    = voted_q | new_ballot;
            yes_mask_d = (yes_mask_q & ~new_ballot) | (bus.ballot_yes & new_ballot);
            timer_d    = timer_q + TMR_W'(1);
            if ((&voted_d) || bus.close || (timer_q == TMR_LAST)) begin
               state_d = ST_TALLY;
            end
         end
         ST_TALLY: begin
            yes_cnt_d = pop;
            pass_d    = (pop_x2 > NV_EXT);
            tie_d     = (pop_x2 == NV_EXT);
            state_d   = ST_RESULT;
         end
         default: begin
            if (bus.start) begin
               state_d    = ST_COLLECT;
               voted_d    = '0;
               yes_mask_d = '0;
               yes_cnt_d  = '0;
               pass_d     = 1'b0;
               tie_d      = 1'b0;
               timer_d    = '0;
            end
         end
      endcase

      // Status flags follow the state being entered so they stay registered
      busy_d = (state_d == ST_COLLECT) || (state_d == ST_TALLY);
      done_d = (state_d == ST_RESULT);
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         voted_q    <= '0;
         yes_mask_q <= '0;
         timer_q    <= '0;
         yes_cnt_q  <= '0;
         pass_q     <= 1'b0;
         tie_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         voted_q    <= voted_d;
         yes_mask_q <= yes_mask_d;
         timer_q    <= timer_d;
         yes_cnt_q  <= yes_cnt_d;
         pass_q     <= pass_d;
         tie_q      <= tie_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.voted   = voted_q;
   assign bus.yes_cnt = yes_cnt_q;
   assign bus.pass    = pass_q;
   assign bus.tie     = tie_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Scoreboard bench for vote_session_ctrl: stimulus queues expectations, monitor checks them.
// Latency: results expected two cycles after the closing ballot/close cycle.
// Backpressure: none.
module tb_vote_session_ctrl;

   typedef struct {
      string      name;
      logic [3:0] voted;
      logic [2:0] cnt;
      logic       pass;
      logic       tie;
      logic       busy;
      logic       done;
      int         cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_chk;
   int   n_fail;
   bit   fin_req;
   bit   fin_ack;
   logic done_prev;

   exp_t snap_q[$];
   exp_t res_q[$];

   vote_session_ctrl_if #(.N_VOTERS(4), .CNT_W(3)) vif ();

   vote_session_ctrl #(
      .N_VOTERS    (4),
      .TIMEOUT_CYC (16),
      .CNT_W       (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (vif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index, advanced on every active edge
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // Monitor: snapshots at their cycle, results whenever done rises
   initial begin
      exp_t e;
      n_chk     = 0;
      n_fail    = 0;
      fin_ack   = 1'b0;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         while (snap_q.size() > 0 && snap_q[0].cyc < cyc) begin
            e = snap_q.pop_front();
            chk({e.name, "_missed"}, 1, 0);
         end
         while (snap_q.size() > 0 && snap_q[0].cyc == cyc) begin
            e = snap_q.pop_front();
            chk({e.name, "_voted"},   int'(vif.voted),   int'(e.voted));
            chk({e.name, "_yes_cnt"}, int'(vif.yes_cnt), int'(e.cnt));
            chk({e.name, "_pass"},    int'(vif.pass),    int'(e.pass));
            chk({e.name, "_tie"},     int'(vif.tie),     int'(e.tie));
            chk({e.name, "_busy"},    int'(vif.busy),    int'(e.busy));
            chk({e.name, "_done"},    int'(vif.done),    int'(e.done));
         end
         if (vif.done === 1'b1 && done_prev !== 1'b1) begin
            if (res_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               e = res_q.pop_front();
               chk({e.name, "_done_cycle"}, cyc,               e.cyc);
               chk({e.name, "_voted"},      int'(vif.voted),   int'(e.voted));
               chk({e.name, "_yes_cnt"},    int'(vif.yes_cnt), int'(e.cnt));
               chk({e.name, "_pass"},       int'(vif.pass),    int'(e.pass));
               chk({e.name, "_tie"},        int'(vif.tie),     int'(e.tie));
               chk({e.name, "_busy"},       int'(vif.busy),    0);
            end
         end
         done_prev = vif.done;
         if (fin_req && !fin_ack) begin
            chk("snapshots_pending", snap_q.size(), 0);
            chk("results_pending",   res_q.size(),  0);
            fin_ack = 1'b1;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_snap(input string nm, input logic [3:0] v, input logic [2:0] c,
                            input logic p, input logic t, input logic b, input logic d,
                            input int at);
      exp_t e;
      e.name = nm; e.voted = v; e.cnt = c; e.pass = p; e.tie = t;
      e.busy = b; e.done = d; e.cyc = at;
      snap_q.push_back(e);
   endtask

   task automatic push_res(input string nm, input logic [3:0] v, input logic [2:0] c,
                           input logic p, input logic t, input int at);
      exp_t e;
      e.name = nm; e.voted = v; e.cnt = c; e.pass = p; e.tie = t;
      e.busy = 1'b0; e.done = 1'b1; e.cyc = at;
      res_q.push_back(e);
   endtask

   // Global watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Directed stimulus
   initial begin
      int s;
      fin_req              = 1'b0;
      rst                  = 1'b1;
      vif.start            = 1'b0;
      vif.close            = 1'b0;
      vif.ballot_valid     = 4'b0000;
      vif.ballot_yes       = 4'b0000;

      // 1. reset, then ballots/close in IDLE are ignored
      tick(2);
      push_snap("reset", 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, cyc);
      rst              = 1'b0;
      vif.ballot_valid = 4'b1111;
      vif.ballot_yes   = 4'b1111;
      vif.close        = 1'b1;
      tick(1);
      push_snap("idle_ignore", 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, cyc);

      // 2. all four vote in one cycle; start during TALLY is ignored
      vif.ballot_valid = 4'b0000;
      vif.ballot_yes   = 4'b0000;
      vif.close        = 1'b0;
      vif.start        = 1'b1;
      tick(1);
      vif.start        = 1'b0;
      push_snap("t2_collect", 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, cyc);
      vif.ballot_valid = 4'b1111;
      vif.ballot_yes   = 4'b1011;
      push_res("t2_result", 4'b1111, 3'd3, 1'b1, 1'b0, cyc + 2);
      tick(1);
      vif.ballot_valid = 4'b0000;
      vif.start        = 1'b1;
      push_snap("t2_tally", 4'b1111, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, cyc);
      tick(1);
      vif.start        = 1'b0;
      push_snap("t2_hold", 4'b1111, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, cyc);
      tick(2);

      // 3. repeat ballot from voter0 ignored (first ballot wins)
      vif.start        = 1'b1;
      tick(1);
      vif.start        = 1'b0;
      vif.ballot_valid = 4'b0001;
      vif.ballot_yes   = 4'b0001;
      tick(1);
      vif.ballot_yes   = 4'b0000;
      tick(1);
      push_snap("t3_repeat", 4'b0001, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, cyc);
      vif.ballot_valid = 4'b1110;
      vif.ballot_yes   = 4'b0000;
      push_res("t3_result", 4'b1111, 3'd1, 1'b0, 1'b0, cyc + 2);
      tick(1);
      vif.ballot_valid = 4'b0000;
      tick(3);

      // 4. timeout after 16 COLLECT cycles; start pulses inside COLLECT ignored
      vif.start = 1'b1;
      s = cyc;
      push_res("t4_timeout", 4'b0011, 3'd2, 1'b0, 1'b1, s + 18);
      tick(1);
      vif.start        = 1'b0;
      vif.ballot_valid = 4'b0011;
      vif.ballot_yes   = 4'b0011;
      push_snap("t4_mid",   4'b0011, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, s + 10);
      push_snap("t4_tally", 4'b0011, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, s + 17);
      tick(1);
      vif.ballot_valid = 4'b0000;
      vif.ballot_yes   = 4'b0000;
      vif.start        = 1'b1;
      tick(1);
      vif.start        = 1'b0;
      tick(1);
      vif.start        = 1'b1;
      tick(1);
      vif.start        = 1'b0;
      tick(15);

      // 5. ballot together with close is recorded; restart from RESULT clears
      vif.start        = 1'b1;
      tick(1);
      vif.start        = 1'b0;
      vif.ballot_valid = 4'b0100;
      vif.ballot_yes   = 4'b0100;
      vif.close        = 1'b1;
      push_res("t5_close", 4'b0100, 3'd1, 1'b0, 1'b0, cyc + 2);
      tick(1);
      vif.ballot_valid = 4'b0000;
      vif.ballot_yes   = 4'b0000;
      vif.close        = 1'b0;
      tick(2);
      vif.start        = 1'b1;
      push_snap("t5_restart", 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, cyc + 1);
      tick(1);
      vif.start        = 1'b0;

      // 6. reset in the middle of COLLECT
      vif.ballot_valid = 4'b0101;
      vif.ballot_yes   = 4'b0101;
      tick(1);
      vif.ballot_valid = 4'b0000;
      vif.ballot_yes   = 4'b0000;
      push_snap("t6_before_rst", 4'b0101, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, cyc);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      push_snap("t6_after_rst", 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, cyc);
      tick(1);

      // Empty session closed immediately: nobody counts as yes
      vif.start = 1'b1;
      tick(1);
      vif.start = 1'b0;
      vif.close = 1'b1;
      push_res("t7_empty", 4'b0000, 3'd0, 1'b0, 1'b0, cyc + 2);
      tick(1);
      vif.close = 1'b0;
      tick(3);

      fin_req = 1'b1;
      for (int i = 0; i < 10 && !fin_ack; i++) begin
         tick(1);
      end
      if (!fin_ack) begin
         $display("FAIL monitor_final: got no acknowledge expected acknowledge");
         $fatal(1, "monitor stalled");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
